// File: rtl/chunked_add_sequencer.sv
// Wide unsigned adder that time-shares one narrow adder_nbit slice, LSB first,
// with the inter-slice carry held in a register.

module adder_nbit #(
    parameter int N_BITS = 4
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              carry_in,
    output logic [N_BITS-1:0] sum,
    output logic              overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{N_BITS{1'b0}}, carry_in};
endmodule

module chunked_add_sequencer #(
    parameter int CHUNK_BITS = 4,
    parameter int NUM_CHUNKS = 4
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             start,
    input  logic [CHUNK_BITS*NUM_CHUNKS-1:0] a,
    input  logic [CHUNK_BITS*NUM_CHUNKS-1:0] b,
    input  logic                             carry_in,
    output logic                             busy,
    output logic                             done,
    output logic [CHUNK_BITS*NUM_CHUNKS-1:0] sum,
    output logic                             overflow
);
    localparam int W     = CHUNK_BITS * NUM_CHUNKS;
    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic                  carry_q;
    logic [W-1:0]          part_q;

    logic [CHUNK_BITS-1:0] a_slice;
    logic [CHUNK_BITS-1:0] b_slice;
    logic [CHUNK_BITS-1:0] add_sum;
    logic                  add_ovf;
    logic [W-1:0]          final_sum;
    logic                  last_chunk;

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (cnt == CNT_W'(i)) begin
                a_slice = a_q[i*CHUNK_BITS +: CHUNK_BITS];
                b_slice = b_q[i*CHUNK_BITS +: CHUNK_BITS];
            end
        end
    end

    adder_nbit #(.N_BITS(CHUNK_BITS)) u_adder (
        .a        (a_slice),
        .b        (b_slice),
        .carry_in (carry_q),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

    // The top slice comes straight from the adder so sum can load on the same edge.
    always_comb begin
        final_sum = part_q;
        final_sum[(NUM_CHUNKS-1)*CHUNK_BITS +: CHUNK_BITS] = add_sum;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            part_q   <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_in;
                        cnt     <= '0;
                        part_q  <= '0;
                        state   <= S_ADD;
                    end
                end
                S_ADD: begin
                    for (int i = 0; i < NUM_CHUNKS; i++) begin
                        if (cnt == CNT_W'(i)) begin
                            part_q[i*CHUNK_BITS +: CHUNK_BITS] <= add_sum;
                        end
                    end
                    carry_q <= add_ovf;
                    if (last_chunk) begin
                        sum      <= final_sum;
                        overflow <= add_ovf;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Directed-vector and random bench for chunked_add_sequencer at the default 4x4 geometry.

module tb_chunked_add_sequencer;
    localparam int CHUNK_BITS = 4;
    localparam int NUM_CHUNKS = 4;
    localparam int W          = CHUNK_BITS * NUM_CHUNKS;

    logic         clk;
    logic         n_rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         overflow;

    int total;
    int bad;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         ov;
    } vec_t;

    vec_t vecs[7];

    chunked_add_sequencer #(
        .CHUNK_BITS(CHUNK_BITS),
        .NUM_CHUNKS(NUM_CHUNKS)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One full operation: drive, scramble inputs after acceptance, check latency and result.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input logic [W-1:0] es, input logic eo, input string nm);
        logic [W-1:0] prev;
        int           lat;
        logic         stable;
        @(negedge clk);
        a        = av;
        b        = bv;
        carry_in = ci;
        start    = 1'b1;
        prev     = sum;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        carry_in = 1'($urandom);
        chk({nm, "_busy_after_start"}, 32'(busy), 32'd1);
        stable = 1'b1;
        lat    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if (done) break;
            if (sum !== prev || busy !== 1'b1) stable = 1'b0;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(NUM_CHUNKS));
        chk({nm, "_sum_held_busy_high"}, 32'(stable), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_overflow"}, 32'(overflow), 32'(eo));
        chk({nm, "_busy_in_done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk({nm, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, "_busy_fall"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [W:0] ref_full;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           ndone;
        logic [W-1:0] seen_sum;

        total    = 0;
        bad      = 0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        n_rst    = 1'b1;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

        // Asynchronous reset between clock edges
        #2 n_rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].ov, $sformatf("vec%0d", i));
        end

        // Reset two edges into an operation discards it
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("midop_rst_busy", 32'(busy), 32'd0);
        chk("midop_rst_done", 32'(done), 32'd0);
        chk("midop_rst_sum", 32'(sum), 32'd0);
        chk("midop_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("midop_rst_no_done", 32'(ndone), 32'd0);
        chk("midop_rst_sum_after", 32'(sum), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "after_rst");

        // start held high with changing operands: second request only after busy drops
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1;
        ndone    = 0;
        seen_sum = '0;
        for (int k = 0; k < NUM_CHUNKS + 1; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                seen_sum = sum;
            end
        end
        chk("held_start_done_count", 32'(ndone), 32'd1);
        chk("held_start_first_sum", 32'(seen_sum), 32'h3333);
        chk("held_start_idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_start_second_accept", 32'(busy), 32'd1);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone = k + 1;
                break;
            end
        end
        chk("held_start_second_latency", 32'(ndone), 32'(NUM_CHUNKS));
        chk("held_start_second_sum", 32'(sum), 32'h0000);
        chk("held_start_second_overflow", 32'(overflow), 32'd1);
        @(posedge clk);
        #1;

        // Random sweep against a W+1-bit reference
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (n % 10 == 0) ra = '1;
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, ref_full[W-1:0], ref_full[W], $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
- Computes a wide unsigned sum A + B + carry_in of NUM_CHUNKS*CHUNK_BITS bits.
- Time-shares a single CHUNK_BITS-wide adder_nbit instance (ports a, b, carry_in, sum, overflow), one slice per cycle, LSB slice first.
- The carry is held in a register between slices.
- Sits between a requesting controller (start/busy/done handshake) and the shared adder. It gives a wide adder at narrow-adder area cost.

Parameters:
CHUNK_BITS, 4, width of the shared adder_nbit instance (>=1)
NUM_CHUNKS, 4, number of slices per operation (>=1); total width W = CHUNK_BITS*NUM_CHUNKS

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  W  operand A, latched on accepted start
b  input  W  operand B, latched on accepted start
carry_in  input  1  initial carry, latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: sum/overflow just updated
sum  output  W  registered result of last completed operation
overflow  output  1  registered carry-out of MSB slice of last completed operation

Behaviour:
- Reset (n_rst=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, overflow=0.
  - Operand, carry and chunk-counter registers are cleared.
  - Reset dominates any in-flight operation; the partial result is discarded and never appears on sum.
- States: IDLE, ADD, DONE. Chunk counter width is max(1, $clog2(NUM_CHUNKS)).
- IDLE:
  - If start=1 at a rising edge: latch a, b, carry_in into internal registers; clear the counter and the partial-sum register; go to ADD.
  - Otherwise stay in IDLE.
- ADD, each cycle:
  - adder_nbit inputs are operand slices [k*CHUNK_BITS +: CHUNK_BITS] (k = counter) plus the carry register.
  - At the edge: write the adder sum into partial-sum slice k and the adder overflow into the carry register.
  - If k < NUM_CHUNKS-1: increment k and stay in ADD.
  - If k == NUM_CHUNKS-1: on the same edge load sum = {final slice, lower partial slices} and overflow = adder overflow, then go to DONE.
- DONE:
  - done=1 for exactly this one cycle.
  - Return to IDLE unconditionally at the next edge.
- Latency: start sampled at edge E0 -> last slice written at edge E0+NUM_CHUNKS -> done high during the cycle after E0+NUM_CHUNKS.
  - busy is high for NUM_CHUNKS+1 cycles, covering ADD and DONE.
  - With NUM_CHUNKS=1, done follows one cycle after start.
- start asserted while busy=1 (ADD or DONE) is ignored and not queued. The requester must re-assert it once busy=0.
- Back-to-back throughput is one operation per NUM_CHUNKS+2 cycles.
- a, b and carry_in may change freely after acceptance; only the latched copies are used.
- sum and overflow change only on the edge entering DONE (or on reset). They hold their value through IDLE and through the entire next operation.
- Arithmetic:
  - Unsigned; sum = (A+B+cin) mod 2^W, overflow = bit W of the full sum.
  - Must equal a single W-bit add for all inputs, including wrap-around 0xFFFF+0+1 -> 0x0000 with overflow=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan (defaults, W=16):
1. Assert n_rst=0 mid-cycle with clk idle -> busy=0, done=0, sum=0x0000, overflow=0 immediately, without waiting for an edge.
2. start=1 for one cycle with a=0x1234, b=0x4321, cin=0 -> busy high for 5 cycles; done pulses exactly 4 edges after the start edge; sum=0x5555, overflow=0.
3. a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, overflow=0 (carry ripples across slice boundaries). Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, overflow=1.
4. Start a=0x1111, b=0x2222. Hold start=1 and change to a=0xAAAA, b=0x5555, cin=1 during ADD/DONE -> only one done pulse with sum=0x3333. A second operation begins only after busy falls, then yields sum=0x0000, overflow=1.
5. Start a=0x0F0F, b=0x0101, then pulse n_rst low two cycles after the start edge -> outputs zero, no done pulse. A subsequent start with 0x0001+0x0001 gives sum=0x0002 at the correct latency.
6. Random sweep of ≥1000 operations against a W+1-bit reference model, with the bench honouring busy -> zero mismatches. sum is stable between done pulses.
